// File: rtl/yarp_pkg.sv
// Shared types for the yarp data-memory path: access sizes, responder states and
// the size/alignment legality check.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // Reserved size (2'b10) is always illegal; half/word must be naturally aligned.
  function automatic logic size_align_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic w_err;
    case (size)
      BYTE:    w_err = 1'b0;
      HALF:    w_err = addr_lo[0];
      WORD:    w_err = (addr_lo != 2'b00);
      default: w_err = 1'b1;
    endcase
    return w_err;
  endfunction

endpackage

// File: rtl/yarp_dmem_align.sv
// Lane steering for data-memory accesses: store byte enables and replicated write
// data, plus extraction and sign/zero extension of load data.
module yarp_dmem_align
  import yarp_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_zero_extnd,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_rd_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be      = 4'b0000;
    o_wr_data = 32'h0;
    o_rd_data = 32'h0;
    w_byte    = i_rd_word[{i_addr_lo, 3'b000} +: 8];
    w_half    = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    case (i_size)
      BYTE: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wr_data = {4{i_wr_data[7:0]}};
        o_rd_data = i_zero_extnd ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      HALF: begin
        o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wr_data = {2{i_wr_data[15:0]}};
        o_rd_data = i_zero_extnd ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      WORD: begin
        o_be      = 4'b1111;
        o_wr_data = i_wr_data;
        o_rd_data = i_rd_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/yarp_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, services it against an
// internal word array after WAIT_CYCLES wait states and returns a one-cycle ack.
module yarp_dmem_responder
  import yarp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  input  logic        zero_extnd_i,
  output logic        data_ack_o,
  output logic [31:0] data_rd_data_o,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_wr;
  logic [31:0] r_wr_data;
  logic        r_zext;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]     w_addr;
  logic [1:0]      w_size;
  logic            w_wr;
  logic [31:0]     w_wr_data;
  logic            w_zext;
  logic [IdxW-1:0] w_idx;
  logic            w_err;
  logic [31:0]     w_rd_word;
  logic [3:0]      w_be;
  logic [31:0]     w_wr_rep;
  logic [31:0]     w_rd_ext;
  logic [31:0]     w_load_data;

  // With zero wait states the result is registered on the acceptance edge, so the
  // live request fields are used in IDLE and the captured ones afterwards.
  always_comb begin
    w_addr    = (r_state == IDLE) ? data_addr_i    : r_addr;
    w_size    = (r_state == IDLE) ? data_byte_i    : r_size;
    w_wr      = (r_state == IDLE) ? data_wr_i      : r_wr;
    w_wr_data = (r_state == IDLE) ? data_wr_data_i : r_wr_data;
    w_zext    = (r_state == IDLE) ? zero_extnd_i   : r_zext;
  end

  assign w_idx       = w_addr[IdxW+1:2];
  assign w_err       = size_align_err(w_size, w_addr[1:0]) |
                       ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_rd_word   = r_mem[w_idx];
  assign w_load_data = (w_wr || w_err) ? 32'h0 : w_rd_ext;

  yarp_dmem_align u_align (
    .i_size       (w_size),
    .i_addr_lo    (w_addr[1:0]),
    .i_zero_extnd (w_zext),
    .i_wr_data    (w_wr_data),
    .i_rd_word    (w_rd_word),
    .o_be         (w_be),
    .o_wr_data    (w_wr_rep),
    .o_rd_data    (w_rd_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      r_addr         <= 32'h0;
      r_size         <= 2'b00;
      r_wr           <= 1'b0;
      r_wr_data      <= 32'h0;
      r_zext         <= 1'b0;
      data_ack_o     <= 1'b0;
      data_rd_data_o <= 32'h0;
      data_err_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      data_ack_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_req_i) begin
            r_addr    <= data_addr_i;
            r_size    <= data_byte_i;
            r_wr      <= data_wr_i;
            r_wr_data <= data_wr_data_i;
            r_zext    <= zero_extnd_i;
            busy_o    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state        <= RESP;
              data_ack_o     <= 1'b1;
              data_rd_data_o <= w_load_data;
              data_err_o     <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state        <= RESP;
            data_ack_o     <= 1'b1;
            data_rd_data_o <= w_load_data;
            data_err_o     <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state        <= IDLE;
          busy_o         <= 1'b0;
          data_rd_data_o <= 32'h0;
          data_err_o     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Store commits on the edge leaving RESP; a reset in WAIT/RESP forces IDLE first.
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_wr && !data_err_o) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wr_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_yarp_dmem_responder.sv
// Bench for yarp_dmem_responder: two instances (0 and 3 wait states) checked every
// cycle against a transaction-level model, plus literal expectations per access.
module tb_yarp_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] addr_s;
  logic [1:0]  size_s;
  logic        wr_s;
  logic [31:0] wd_s;
  logic        zx_s;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [1:0]  busy;
  logic [31:0] rd [2];

  int n_vec  = 0;
  int n_fail = 0;

  yarp_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk            (clk),
    .reset_n        (rst_n),
    .data_req_i     (req[0]),
    .data_addr_i    (addr_s),
    .data_byte_i    (size_s),
    .data_wr_i      (wr_s),
    .data_wr_data_i (wd_s),
    .zero_extnd_i   (zx_s),
    .data_ack_o     (ack[0]),
    .data_rd_data_o (rd[0]),
    .data_err_o     (err[0]),
    .busy_o         (busy[0])
  );

  yarp_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
    .clk            (clk),
    .reset_n        (rst_n),
    .data_req_i     (req[1]),
    .data_addr_i    (addr_s),
    .data_byte_i    (size_s),
    .data_wr_i      (wr_s),
    .data_wr_data_i (wd_s),
    .zero_extnd_i   (zx_s),
    .data_ack_o     (ack[1]),
    .data_rd_data_o (rd[1]),
    .data_err_o     (err[1]),
    .busy_o         (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          lat_cfg [2] = '{0, 3};
  int          m_left  [2] = '{0, 0};
  logic        m_err   [2];
  logic [31:0] m_rd    [2];
  logic        m_rd_ok [2];
  logic        m_st    [2];
  logic [31:0] m_st_a  [2];
  logic [1:0]  m_st_sz [2];
  logic [31:0] m_st_d  [2];
  logic [31:0] m_mem   [int];

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 1'b1;
    if (sz == 2'b01 && a % 2 != 0) return 1'b1;
    if (sz == 2'b11 && a % 4 != 0) return 1'b1;
    return (a / 4) >= 1024;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic zx);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    if (sz == 2'b00) begin
      v = v & 32'hFF;
      if (!zx && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (!zx && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_left[d] = 0;
        m_st[d]   = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_left[d] > 0) begin
          m_left[d]--;
          if (m_left[d] == 0 && m_st[d]) begin
            int key;
            int n;
            logic [31:0] w;
            key = d * 65536 + int'(m_st_a[d] / 4);
            w   = m_mem.exists(key) ? m_mem[key] : 32'h0;
            n   = (m_st_sz[d] == 2'b00) ? 1 : (m_st_sz[d] == 2'b01) ? 2 : 4;
            for (int k = 0; k < n; k++) begin
              int lane;
              lane = int'(m_st_a[d] % 4) + k;
              w = (w & ~(32'hFF << (8 * lane))) | (((m_st_d[d] >> (8 * k)) & 32'hFF) << (8 * lane));
            end
            m_mem[key] = w;
            m_st[d] = 1'b0;
          end
        end else if (req[d]) begin
          int key;
          key        = d * 65536 + int'(addr_s / 4);
          m_left[d]  = lat_cfg[d] + 1;
          m_err[d]   = model_err(size_s, addr_s);
          m_rd[d]    = 32'h0;
          m_rd_ok[d] = 1'b1;
          m_st[d]    = wr_s && !m_err[d];
          m_st_a[d]  = addr_s;
          m_st_sz[d] = size_s;
          m_st_d[d]  = wd_s;
          if (!wr_s && !m_err[d]) begin
            if (m_mem.exists(key)) m_rd[d] = model_load(m_mem[key], size_s, addr_s, zx_s);
            else m_rd_ok[d] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic e_ack;
      e_ack = (m_left[d] == 1);
      chk($sformatf("ack%0d", d), {31'h0, ack[d]}, {31'h0, e_ack});
      chk($sformatf("busy%0d", d), {31'h0, busy[d]}, {31'h0, m_left[d] > 0});
      chk($sformatf("err%0d", d), {31'h0, err[d]}, {31'h0, e_ack && m_err[d]});
      if (!e_ack || m_rd_ok[d]) chk($sformatf("rd%0d", d), rd[d], e_ack ? m_rd[d] : 32'h0);
    end
  end

  // ---------------- driver ----------------
  task automatic xact(input int d, input logic [1:0] sz, input logic [31:0] a,
                      input logic wr, input logic [31:0] wd, input logic zx,
                      output logic [31:0] rd_v, output logic err_v, output int lat);
    @(negedge clk);
    size_s = sz; addr_s = a; wr_s = wr; wd_s = wd; zx_s = zx;
    req[d] = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[d] && lat < 20);
    if (!ack[d]) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout dut%0d addr %h: no ack after %0d cycles", d, a, lat);
    end
    rd_v  = rd[d];
    err_v = err[d];
    req[d] = 1'b0;
  endtask

  task automatic op(input string name, input int d, input logic [1:0] sz, input logic [31:0] a,
                    input logic wr, input logic [31:0] wd, input logic zx,
                    input logic [31:0] e_rd, input logic e_err);
    logic [31:0] rv;
    logic        ev;
    int          lat;
    xact(d, sz, a, wr, wd, zx, rv, ev, lat);
    chk({name, "_rd"}, rv, e_rd);
    chk({name, "_err"}, {31'h0, ev}, {31'h0, e_err});
    chk({name, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_seen;
    rst_n = 1'b0; req = 2'b00;
    addr_s = 32'h0; size_s = 2'b00; wr_s = 1'b0; wd_s = 32'h0; zx_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ack, err, busy, rd[0][7:0] | rd[1][7:0]}, 14'h0);
    rst_n = 1'b1;

    // Zero wait states: word, byte, half and error cases
    op("st_w10",     0, 2'b11, 32'h10,   1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    op("ld_w10",     0, 2'b11, 32'h10,   1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    op("ld_b13_s",   0, 2'b00, 32'h13,   1'b0, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0);
    op("ld_b13_z",   0, 2'b00, 32'h13,   1'b0, 32'h0,        1'b1, 32'h000000DE, 1'b0);
    op("ld_h10_s",   0, 2'b01, 32'h10,   1'b0, 32'h0,        1'b0, 32'hFFFFBEEF, 1'b0);
    op("st_b11",     0, 2'b00, 32'h11,   1'b1, 32'h12345655, 1'b0, 32'h0,        1'b0);
    op("ld_w10_b",   0, 2'b11, 32'h10,   1'b0, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    op("ld_h11_mis", 0, 2'b01, 32'h11,   1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
    op("st_w12_mis", 0, 2'b11, 32'h12,   1'b1, 32'hAAAAAAAA, 1'b0, 32'h0,        1'b1);
    op("ld_w10_c",   0, 2'b11, 32'h10,   1'b0, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    op("ld_oor",     0, 2'b11, 32'h1000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
    op("ld_rsvd",    0, 2'b10, 32'h10,   1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
    op("st_w14",     0, 2'b11, 32'h14,   1'b1, 32'h01234567, 1'b0, 32'h0,        1'b0);
    op("st_h16",     0, 2'b01, 32'h16,   1'b1, 32'h9999ABCD, 1'b0, 32'h0,        1'b0);
    op("ld_h16_z",   0, 2'b01, 32'h16,   1'b0, 32'h0,        1'b1, 32'h0000ABCD, 1'b0);
    op("ld_b15_s",   0, 2'b00, 32'h15,   1'b0, 32'h0,        1'b0, 32'h00000045, 1'b0);
    op("ld_w14",     0, 2'b11, 32'h14,   1'b0, 32'h0,        1'b0, 32'hABCD4567, 1'b0);

    // Three wait states, then a store aborted by reset while waiting
    op("w3_st_w20",  1, 2'b11, 32'h20,   1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0);
    op("w3_ld_w20",  1, 2'b11, 32'h20,   1'b0, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0);
    op("w3_ld_b22",  1, 2'b00, 32'h22,   1'b0, 32'h0,        1'b0, 32'hFFFFFFFE, 1'b0);

    @(negedge clk);
    size_s = 2'b11; addr_s = 32'h20; wr_s = 1'b1; wd_s = 32'h11111111; zx_s = 1'b0;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", {31'h0, busy[1]}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {ack, err, busy, rd[1]}, 38'h0);
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1]) acks_seen++;
    end
    chk("abort_no_ack", 32'(acks_seen), 32'h0);
    op("w3_ld_w20_b", 1, 2'b11, 32'h20,  1'b0, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0);
    op("ld_w10_post", 0, 2'b11, 32'h10,  1'b0, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
